// File: rtl/rc4_pkg.sv
// Shared RC4 types and constants for the S-array stages (init, KSA, PRGA).
package rc4_pkg;

    localparam int         BYTE_W = 8;
    localparam int         S_SIZE = 256;
    localparam logic [7:0] S_LAST = 8'd255;
    localparam int         KIDX_W = 3;

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        CALC_J,
        RD_SJ,
        WAIT_SJ,
        WR_SI,
        WR_SJ,
        DONE
    } ksa_state_t;

    // Wrap counter for the key byte index; avoids a divider for i mod KEY_LEN.
    function automatic logic [KIDX_W-1:0] next_kidx(input logic [KIDX_W-1:0] k, input int key_len);
        return (k == KIDX_W'(key_len - 1)) ? '0 : k + 1'b1;
    endfunction

    function automatic logic is_read_state(input ksa_state_t s);
        return s inside {RD_SI, WAIT_SI, RD_SJ, WAIT_SJ};
    endfunction

endpackage

// File: rtl/key_byte_sel.sv
// Combinational selection of byte kidx from a packed secret key (byte 0 is the MSB byte).
module key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3
) (
    input  logic [BYTE_W*KEY_LEN-1:0] secret_key,
    input  logic [KIDX_W-1:0]         kidx,
    output logic [BYTE_W-1:0]         key_byte
);

    logic [BYTE_W-1:0] key_bytes [KEY_LEN];

    generate
        for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_bytes
            assign key_bytes[gi] = secret_key[BYTE_W*(KEY_LEN-gi)-1 -: BYTE_W];
        end
    endgenerate

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (kidx == KIDX_W'(k)) begin
                key_byte = key_bytes[k];
            end
        end
    end

endmodule

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap stage driving the shared single-port S RAM.
// Optional macro KSA_IDX_EQ_SKIP_EN skips the read/write of S[j] when the new j equals i.
module ksa_swap_fsm
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic [BYTE_W*KEY_LEN-1:0] secret_key,
    input  logic [BYTE_W-1:0]         q,
    output logic [BYTE_W-1:0]         address,
    output logic [BYTE_W-1:0]         data,
    output logic                      wren,
    output logic                      rden,
    output logic                      complete
);

    localparam int                WAIT_W  = $clog2(RD_LAT + 1);
    // Address is registered, so RAM data arrives RD_LAT cycles after the cycle following RD_*.
    // CALC_J samples S[i] itself; WAIT_SJ needs one extra cycle to sample S[j].
    localparam logic [WAIT_W-1:0] SI_LAST = WAIT_W'(RD_LAT - 1);
    localparam logic [WAIT_W-1:0] SJ_LAST = WAIT_W'(RD_LAT);

    ksa_state_t         state_reg, state_next;
    logic [7:0]         i_reg, i_next;
    logic [7:0]         j_reg, j_next;
    logic [KIDX_W-1:0]  kidx_reg, kidx_next;
    logic [7:0]         si_reg, si_next;
    logic [7:0]         sj_reg, sj_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic [7:0]         address_reg, address_next;
    logic [7:0]         data_reg, data_next;
    logic               wren_reg, wren_next;
    logic               rden_reg, rden_next;
    logic               complete_reg, complete_next;
    logic               advance;
    logic [7:0]         key_byte;

    key_byte_sel #(
        .KEY_LEN (KEY_LEN)
    ) u_key_byte_sel (
        .secret_key (secret_key),
        .kidx       (kidx_reg),
        .key_byte   (key_byte)
    );

    always_comb begin
        state_next    = state_reg;
        i_next        = i_reg;
        j_next        = j_reg;
        kidx_next     = kidx_reg;
        si_next       = si_reg;
        sj_next       = sj_reg;
        wait_next     = wait_reg;
        address_next  = address_reg;
        data_next     = data_reg;
        wren_next     = 1'b0;
        complete_next = complete_reg;
        advance       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && !complete_reg) begin
                    state_next = RD_SI;
                end
            end
            RD_SI: begin
                address_next = i_reg;
                wait_next    = '0;
                state_next   = WAIT_SI;
            end
            WAIT_SI: begin
                if (wait_reg == SI_LAST) begin
                    wait_next  = '0;
                    state_next = CALC_J;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            CALC_J: begin
                si_next    = q;
                j_next     = j_reg + q + key_byte;
                state_next = RD_SJ;
            end
            RD_SJ: begin
`ifdef KSA_IDX_EQ_SKIP_EN
                if (j_reg == i_reg) begin
                    advance = 1'b1;
                end else begin
                    address_next = j_reg;
                    wait_next    = '0;
                    state_next   = WAIT_SJ;
                end
`else
                address_next = j_reg;
                wait_next    = '0;
                state_next   = WAIT_SJ;
`endif
            end
            WAIT_SJ: begin
                if (wait_reg == SJ_LAST) begin
                    sj_next    = q;
                    wait_next  = '0;
                    state_next = WR_SI;
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            WR_SI: begin
                address_next = i_reg;
                data_next    = sj_reg;
                wren_next    = 1'b1;
                state_next   = WR_SJ;
            end
            WR_SJ: begin
                address_next = j_reg;
                data_next    = si_reg;
                wren_next    = 1'b1;
                advance      = 1'b1;
            end
            DONE: begin
                complete_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // i wraps 255 -> 0 on the way to DONE; j is kept until a re-arm.
        if (advance) begin
            i_next     = i_reg + 8'd1;
            kidx_next  = next_kidx(kidx_reg, KEY_LEN);
            state_next = (i_reg == S_LAST) ? DONE : RD_SI;
        end

        if (state_next == DONE) begin
            complete_next = 1'b1;
        end

        rden_next = is_read_state(state_next);

        if (stop) begin
            state_next    = IDLE;
            i_next        = '0;
            j_next        = '0;
            kidx_next     = '0;
            wait_next     = '0;
            wren_next     = 1'b0;
            rden_next     = 1'b0;
            complete_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            i_reg        <= '0;
            j_reg        <= '0;
            kidx_reg     <= '0;
            si_reg       <= '0;
            sj_reg       <= '0;
            wait_reg     <= '0;
            address_reg  <= '0;
            data_reg     <= '0;
            wren_reg     <= 1'b0;
            rden_reg     <= 1'b0;
            complete_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            i_reg        <= i_next;
            j_reg        <= j_next;
            kidx_reg     <= kidx_next;
            si_reg       <= si_next;
            sj_reg       <= sj_next;
            wait_reg     <= wait_next;
            address_reg  <= address_next;
            data_reg     <= data_next;
            wren_reg     <= wren_next;
            rden_reg     <= rden_next;
            complete_reg <= complete_next;
        end
    end

    assign address  = address_reg;
    assign data     = data_reg;
    assign wren     = wren_reg;
    assign rden     = rden_reg;
    assign complete = complete_reg;

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Self-checking bench for ksa_swap_fsm: RAM model plus a plain RC4 KSA reference model.
module tb_ksa_swap_fsm;

    localparam int KEY_LEN = 3;
    localparam int RD_LAT  = 1;
`ifdef KSA_IDX_EQ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        rden;
    logic        complete;

    int checks = 0;
    int errors = 0;

    ksa_swap_fsm #(
        .KEY_LEN (KEY_LEN),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .rden       (rden),
        .complete   (complete)
    );

    always #5 clk = ~clk;

    // RAM: registered read with RD_LAT stages, read-before-write.
    logic [7:0]  mem [256];
    logic [7:0]  q_pipe [RD_LAT];
    logic        preload = 1'b0;
    logic [15:0] wr_log [$];

    assign q = q_pipe[RD_LAT-1];

    always @(posedge clk) begin
        q_pipe[0] <= mem[address];
        for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[address] <= data;
            wr_log.push_back({address, data});
        end
    end

    // Reference model results.
    logic [7:0]  model_s [256];
    logic [15:0] exp_wr [$];
    int          iter_start [257];
    int          wr_before [257];
    int          exp_cycles;

    function automatic void compute_model(input logic [23:0] key);
        int j, t, cyc, kb, i;
        for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
        exp_wr.delete();
        j = 0;
        cyc = 0;
        for (i = 0; i < 256; i++) begin
            iter_start[i] = cyc;
            wr_before[i]  = exp_wr.size();
            kb = int'((key >> (8 * (KEY_LEN - 1 - (i % KEY_LEN)))) & 24'hFF);
            j = (j + int'(model_s[i]) + kb) % 256;
            if (SKIP && j == i) begin
                cyc += 3 + RD_LAT;
            end else begin
                exp_wr.push_back({8'(i), model_s[j]});
                exp_wr.push_back({8'(j), model_s[i]});
                t = model_s[i];
                model_s[i] = model_s[j];
                model_s[j] = 8'(t);
                cyc += 6 + 2 * RD_LAT;
            end
        end
        iter_start[256] = cyc;
        wr_before[256]  = exp_wr.size();
        exp_cycles = cyc;
    endfunction

    task automatic preload_identity();
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({address, data, wren, rden, complete} !== 19'd0) begin
            errors++;
            $display("FAIL reset_init: outputs got %h/%h/%b/%b/%b, expected all 0", address, data, wren, rden, complete);
        end
        reset = 1'b0;
        preload_identity();
        secret_key = 24'h4A7F13;
        start = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({address, data, wren, rden, complete} !== 19'd0) begin
            errors++;
            $display("FAIL reset_midrun: outputs got %h/%h/%b/%b/%b, expected all 0", address, data, wren, rden, complete);
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wren, rden, complete} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: wren/rden/complete got %b%b%b, expected 000", wren, rden, complete);
        end
        $display("test_reset done");
    endtask

    // Full run with start held high throughout (it must be ignored while busy and in DONE).
    task automatic run_ksa(input logic [23:0] key, input string name);
        int  cyc, bad, first_bad;
        bit  done;
        compute_model(key);
        preload_identity();
        wr_log.delete();
        secret_key = key;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (complete === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || cyc != exp_cycles) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles (done=%0b), expected %0d", name, cyc, done, exp_cycles);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (complete !== 1'b1 || wren !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_hold: complete=%b wren=%b, expected 1 and 0", name, complete, wren);
        end
        checks++;
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < exp_wr.size() && k < wr_log.size(); k++) begin
            if (wr_log[k] !== exp_wr[k]) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        if (wr_log.size() != exp_wr.size() || bad != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes (%0d differ, first at %0d), expected %0d", name, wr_log.size(), bad, first_bad, exp_wr.size());
        end
        checks++;
        bad = 0;
        first_bad = -1;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== model_s[k]) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_final_s: %0d bytes differ, first S[%0d] got %h expected %h", name, bad, first_bad,
                     mem[first_bad < 0 ? 0 : first_bad], model_s[first_bad < 0 ? 0 : first_bad]);
        end
        start = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        checks++;
        if (complete !== 1'b0) begin
            errors++;
            $display("FAIL %s_rearm: complete got %b, expected 0", name, complete);
        end
        $display("run %s key=%h cycles=%0d writes=%0d", name, key, cyc, wr_log.size());
    endtask

    task automatic test_key_zero();
        int base;
        run_ksa(24'h000000, "key_zero");
        base = SKIP ? 0 : 4;
        checks++;
        if (wr_log.size() < base + 2 || wr_log[base] !== 16'h0203 || wr_log[base+1] !== 16'h0302) begin
            errors++;
            $display("FAIL key_zero_it2: writes at %0d got %h %h, expected 0203 0302", base,
                     wr_log.size() > base ? wr_log[base] : 16'hxxxx, wr_log.size() > base + 1 ? wr_log[base+1] : 16'hxxxx);
        end
    endtask

    task automatic test_key_010203();
        run_ksa(24'h010203, "key_010203");
        checks++;
        if (wr_log.size() < 4 || wr_log[0] !== 16'h0001 || wr_log[1] !== 16'h0100 ||
            wr_log[2] !== 16'h0103 || wr_log[3] !== 16'h0300) begin
            errors++;
            $display("FAIL key_010203_it01: first writes got %h %h %h %h, expected 0001 0100 0103 0300",
                     wr_log.size() > 0 ? wr_log[0] : 16'hxxxx, wr_log.size() > 1 ? wr_log[1] : 16'hxxxx,
                     wr_log.size() > 2 ? wr_log[2] : 16'hxxxx, wr_log.size() > 3 ? wr_log[3] : 16'hxxxx);
        end
    endtask

    task automatic test_stop();
        logic [23:0] key;
        int cyc, target, bad;
        key = 24'($urandom);
        compute_model(key);
        preload_identity();
        wr_log.delete();
        secret_key = key;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        target = (wr_before[101] == wr_before[100]) ? iter_start[100] + RD_LAT + 1
                                                    : iter_start[100] + 2 * RD_LAT + 4;
        while (cyc < target) begin
            @(posedge clk); #1;
            cyc++;
        end
        stop = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wren !== 1'b0 || rden !== 1'b0 || complete !== 1'b0) begin
            errors++;
            $display("FAIL stop_next: wren/rden/complete got %b%b%b, expected 000", wren, rden, complete);
        end
        stop = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wren !== 1'b0 || rden !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: wren/rden got %b%b, expected 00", wren, rden);
        end
        checks++;
        bad = 0;
        for (int k = 0; k < wr_before[100] && k < wr_log.size(); k++) begin
            if (wr_log[k] !== exp_wr[k]) bad++;
        end
        if (wr_log.size() != wr_before[100] || bad != 0) begin
            errors++;
            $display("FAIL stop_partial: got %0d writes (%0d differ), expected %0d", wr_log.size(), bad, wr_before[100]);
        end
        $display("test_stop key=%h stopped at cycle %0d writes=%0d", key, target, wr_log.size());
    endtask

    initial begin
        test_reset();
        test_key_zero();
        test_key_010203();
        run_ksa(24'h4A7F13, "golden");
        test_stop();
        run_ksa(24'($urandom), "restart");
        run_ksa(24'($urandom), "back_to_back");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
